// File: rtl/wb_arbiter.sv
// wb_arbiter: serializes ALU and queued MEM results onto one register-file write port.
// Optional WB_BYPASS_EN lets a MEM result skip the empty FIFO when the ALU is idle.
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [63:0]              alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_rd,
  input  logic [63:0]              mem_data,
  output logic                     wen,
  output logic [4:0]               waddr,
  output logic [63:0]              wdata,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0]       q_rd   [DEPTH];
  logic [63:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_live;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop, byp, squash, live_in;
  assign mem_ready = fifo_count < (AW+1)'(DEPTH);
  assign pop = !alu_valid && fifo_count != '0;
`ifdef WB_BYPASS_EN
  assign byp = !alu_valid && fifo_count == '0 && mem_valid;
`else
  assign byp = 1'b0;
`endif
  assign push = mem_valid && mem_ready && !byp;
  assign squash = alu_valid && alu_rd != '0;
  // the ALU result is younger, so a same-cycle MEM result to the same rd is dead on arrival
  assign live_in = !(squash && mem_rd == alu_rd);
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= mem_rd;
      q_data[wr_ptr] <= mem_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen        <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      q_live     <= '0;
    end else begin
      wen <= alu_valid ? alu_rd != '0 : pop ? q_live[rd_ptr] && q_rd[rd_ptr] != '0 : byp && mem_rd != '0;
      if (alu_valid) begin
        waddr <= alu_rd;
        wdata <= alu_data;
      end else if (pop) begin
        waddr <= q_rd[rd_ptr];
        wdata <= q_data[rd_ptr];
      end else if (byp) begin
        waddr <= mem_rd;
        wdata <= mem_data;
      end
      for (int i = 0; i < DEPTH; i++)
        if (squash && q_rd[i] == alu_rd) q_live[i] <= 1'b0;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push) begin
        q_live[wr_ptr] <= live_in;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      fifo_count <= push && !pop ? fifo_count + 1'b1 : pop && !push ? fifo_count - 1'b1 : fifo_count;
    end
  end
endmodule
